// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction/memory/datapath control bundle between mc_controller (master) and the datapath (slave)
interface mc_controller_if #(
    parameter int ALU_OP_W = 3
);
    logic [31:0]         instr;
    logic                mem_ready;
    logic                zero;
    logic                mem_req;
    logic                iord;
    logic                memwrite;
    logic                irwrite;
    logic                pc_en;
    logic [1:0]          pcsrc;
    logic                regwrite;
    logic                regdst;
    logic                mem2reg;
    logic                alusrc_a;
    logic [1:0]          alusrc_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal;
    logic                mem_timeout;
    logic [3:0]          state;
    modport master (
        input  instr, mem_ready, zero,
        output mem_req, iord, memwrite, irwrite, pc_en, pcsrc, regwrite, regdst, mem2reg,
               alusrc_a, alusrc_b, alu_op, illegal, mem_timeout, state
    );
    modport slave (
        output instr, mem_ready, zero,
        input  mem_req, iord, memwrite, irwrite, pc_en, pcsrc, regwrite, regdst, mem2reg,
               alusrc_a, alusrc_b, alu_op, illegal, mem_timeout, state
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with mem_ready timeout abort; beq/j enabled by MC_CONTROLLER_BRANCH_EN
module mc_controller #(
    parameter int ALU_OP_W = 3,
    parameter int TIMEOUT  = 15
) (
    input logic             clk,
    input logic             rst_n,
    mc_controller_if.master bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        ALUWB  = 4'd3,
        ADDIEX = 4'd4,
        ADDIWB = 4'd5,
        MEMADR = 4'd6,
        MEMRD  = 4'd7,
        MEMWB  = 4'd8,
        MEMWR  = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    opcode;
    logic [2:0]    funct_op, op;
    logic          funct_ok, waiting, abort;
    logic          mem_req, iord, memwrite, irwrite, pc_en, regwrite, regdst, mem2reg, alusrc_a, illegal;
    logic [1:0]    pcsrc, alusrc_b;
    assign opcode  = bus.instr[31:26];
    assign waiting = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign abort   = (TIMEOUT > 0) && waiting && !bus.mem_ready && (cnt_q == CW'(TIMEOUT));
    // R-type funct to ALU operation; the IR is stable, so ALUWB re-reads the same decode
    always_comb begin
        funct_op = 3'b000;
        funct_ok = 1'b1;
        case (bus.instr[5:0])
            6'b100000: funct_op = 3'b000;
            6'b100100: funct_op = 3'b100;
            6'b100101: funct_op = 3'b010;
            6'b100010: funct_op = 3'b011;
            6'b101010: funct_op = 3'b111;
            default:   funct_ok = 1'b0;
        endcase
    end
    // Per-state control decode and next-state selection
    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        pc_en    = 1'b0;
        pcsrc    = 2'b00;
        regwrite = 1'b0;
        regdst   = 1'b0;
        mem2reg  = 1'b0;
        alusrc_a = 1'b0;
        alusrc_b = 2'b00;
        op       = 3'b000;
        illegal  = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req  = 1'b1;
                alusrc_b = 2'b01;
                irwrite  = bus.mem_ready;
                pc_en    = bus.mem_ready;
                state_d  = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrc_b = 2'b11;
                case (opcode)
                    6'b000000:            state_d = EXEC;
                    6'b001000:            state_d = ADDIEX;
                    6'b100011, 6'b101011: state_d = MEMADR;
`ifdef MC_CONTROLLER_BRANCH_EN
                    6'b000100:            state_d = BRANCH;
                    6'b000010:            state_d = JUMP;
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            EXEC: begin
                alusrc_a = 1'b1;
                op       = funct_op;
                illegal  = !funct_ok;
                state_d  = funct_ok ? ALUWB : FETCH;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                op       = funct_op;
                state_d  = FETCH;
            end
            ADDIEX: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                state_d  = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            MEMADR: begin
                alusrc_a = 1'b1;
                alusrc_b = 2'b10;
                state_d  = opcode[3] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = bus.mem_ready ? MEMWB : (abort ? FETCH : MEMRD);
            end
            MEMWB: begin
                regwrite = 1'b1;
                mem2reg  = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                state_d  = (bus.mem_ready || abort) ? FETCH : MEMWR;
            end
`ifdef MC_CONTROLLER_BRANCH_EN
            BRANCH: begin
                alusrc_a = 1'b1;
                op       = 3'b011;
                pcsrc    = 2'b01;
                pc_en    = bus.zero;
                state_d  = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pc_en   = 1'b1;
                state_d = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end
    // Wait counter restarts on any state change or abort and counts cycles without mem_ready
    always_comb begin
        cnt_d = (abort || state_d != state_q) ? '0 : ((waiting && !bus.mem_ready) ? cnt_q + CW'(1) : cnt_q);
    end
    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.mem_req     = rst_n & mem_req;
    assign bus.memwrite    = rst_n & memwrite;
    assign bus.irwrite     = rst_n & irwrite;
    assign bus.pc_en       = rst_n & pc_en;
    assign bus.regwrite    = rst_n & regwrite;
    assign bus.illegal     = rst_n & illegal;
    assign bus.mem_timeout = rst_n & abort;
    assign bus.iord        = iord;
    assign bus.pcsrc       = pcsrc;
    assign bus.regdst      = regdst;
    assign bus.mem2reg     = mem2reg;
    assign bus.alusrc_a    = alusrc_a;
    assign bus.alusrc_b    = alusrc_b;
    assign bus.alu_op      = ALU_OP_W'(op);
    assign bus.state       = state_q;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-instruction cycle traces of mc_controller checked against an instruction-level model
module tb_mc_controller;
    localparam int TO = 15;
    localparam logic [17:0] MREQ = 18'h20000, IORD = 18'h10000, MW = 18'h08000, IRW = 18'h04000;
    localparam logic [17:0] PCE = 18'h02000, PCS2 = 18'h01000, PCS1 = 18'h00800, RW = 18'h00400;
    localparam logic [17:0] RD = 18'h00200, M2R = 18'h00100, ASA = 18'h00080;
    localparam logic [17:0] ASB1 = 18'h00020, ASB2 = 18'h00040, ASB3 = 18'h00060;
    localparam logic [17:0] ILL = 18'h00002, TOUT = 18'h00001;
    typedef struct {
        logic [3:0]  st;
        logic [17:0] cw;
        logic        rdy;
        logic        z;
    } step_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tests = 0;
    int          fails = 0;
    step_t       exp_q[$];
    logic [3:0]  obs_st[$];
    logic [17:0] obs_cw[$];
    logic [17:0] dut_cw;
    mc_controller_if #(.ALU_OP_W(3)) bus ();
    mc_controller #(.ALU_OP_W(3), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign dut_cw = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pc_en, bus.pcsrc, bus.regwrite,
                     bus.regdst, bus.mem2reg, bus.alusrc_a, bus.alusrc_b, bus.alu_op, bus.illegal, bus.mem_timeout};

    function automatic logic [17:0] opw(input logic [2:0] o);
        return {13'd0, o, 2'd0};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic bit funct_op(input logic [5:0] f, output logic [2:0] o);
        o = 3'b000;
        case (f)
            6'h20:   o = 3'b000;
            6'h24:   o = 3'b100;
            6'h25:   o = 3'b010;
            6'h22:   o = 3'b011;
            6'h2A:   o = 3'b111;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic push(input logic [3:0] st, input logic [17:0] cw, input logic rdy, input logic z);
        step_t s;
        s.st = st;
        s.cw = cw;
        s.rdy = rdy;
        s.z = z;
        exp_q.push_back(s);
    endtask

    // nw < 0: memory never answers, so TO silent cycles then an abort cycle
    task automatic wait_phase(input logic [3:0] st, input int nw, input logic [17:0] busy, input logic [17:0] done, output bit ok);
        int n = (nw < 0) ? TO : nw;
        for (int i = 0; i < n; i++) push(st, busy, 1'b0, rb());
        if (nw < 0) push(st, busy | TOUT, 1'b0, rb());
        else push(st, done, 1'b1, rb());
        ok = (nw >= 0);
    endtask

    task automatic build(input logic [31:0] ins, input int fw, input int mw);
        logic [2:0] fo;
        bit ok;
        bit fok;
        exp_q.delete();
        wait_phase(4'd0, fw, MREQ | ASB1, MREQ | ASB1 | IRW | PCE, ok);
        if (!ok) return;
        push(4'd1, ASB3 | ((ins[31:26] inside {6'h00, 6'h08, 6'h23, 6'h2B
`ifdef MC_CONTROLLER_BRANCH_EN
            , 6'h04, 6'h02
`endif
            }) ? 18'h0 : ILL), rb(), rb());
        case (ins[31:26])
            6'h00: begin
                fok = funct_op(ins[5:0], fo);
                if (fok) begin
                    push(4'd2, ASA | opw(fo), rb(), rb());
                    push(4'd3, RW | RD | opw(fo), rb(), rb());
                end else push(4'd2, ASA | ILL, rb(), rb());
            end
            6'h08: begin
                push(4'd4, ASA | ASB2, rb(), rb());
                push(4'd5, RW, rb(), rb());
            end
            6'h23: begin
                push(4'd6, ASA | ASB2, rb(), rb());
                wait_phase(4'd7, mw, MREQ | IORD, MREQ | IORD, ok);
                if (ok) push(4'd8, RW | M2R, rb(), rb());
            end
            6'h2B: begin
                push(4'd6, ASA | ASB2, rb(), rb());
                wait_phase(4'd9, mw, MREQ | IORD | MW, MREQ | IORD | MW, ok);
            end
`ifdef MC_CONTROLLER_BRANCH_EN
            6'h04: begin
                fok = rb();
                push(4'd10, ASA | opw(3'b011) | PCS1 | (fok ? PCE : 18'h0), rb(), fok);
            end
            6'h02: push(4'd11, PCS2 | PCE, rb(), rb());
`endif
            default: ;
        endcase
    endtask

    task automatic drive(input logic [31:0] ins);
        obs_st.delete();
        obs_cw.delete();
        foreach (exp_q[i]) begin
            @(negedge clk);
            bus.instr = ins;
            bus.mem_ready = exp_q[i].rdy;
            bus.zero = exp_q[i].z;
            #1;
            obs_st.push_back(bus.state);
            obs_cw.push_back(dut_cw);
        end
    endtask

    task automatic test_reset();
        bus.instr = 32'h0;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        rst_n = 1'b0;
        #12;
        tests++;
        if (bus.state !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        tests++;
        if (dut_cw !== ASB1) begin
            fails++;
            $display("FAIL reset_ctl: got %05h expected %05h", dut_cw, ASB1);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        build(32'h00221820, 0, 0);
        drive(32'h00221820);
        foreach (exp_q[i]) begin
            tests++;
            if ({obs_st[i], obs_cw[i]} !== {exp_q[i].st, exp_q[i].cw}) begin
                fails++;
                $display("FAIL add step %0d: state=%0d ctl=%05h expected state=%0d ctl=%05h", i, obs_st[i], obs_cw[i], exp_q[i].st, exp_q[i].cw);
            end
        end
    endtask

    task automatic test_lw_wait();
        build(32'h8C220004, 0, 3);
        drive(32'h8C220004);
        foreach (exp_q[i]) begin
            tests++;
            if ({obs_st[i], obs_cw[i]} !== {exp_q[i].st, exp_q[i].cw}) begin
                fails++;
                $display("FAIL lw_wait step %0d: state=%0d ctl=%05h expected state=%0d ctl=%05h", i, obs_st[i], obs_cw[i], exp_q[i].st, exp_q[i].cw);
            end
        end
    endtask

    task automatic test_sw_timeout();
        build(32'hAC220004, 0, -1);
        drive(32'hAC220004);
        foreach (exp_q[i]) begin
            tests++;
            if ({obs_st[i], obs_cw[i]} !== {exp_q[i].st, exp_q[i].cw}) begin
                fails++;
                $display("FAIL sw_timeout step %0d: state=%0d ctl=%05h expected state=%0d ctl=%05h", i, obs_st[i], obs_cw[i], exp_q[i].st, exp_q[i].cw);
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if ({bus.state, bus.memwrite, bus.mem_timeout} !== {4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL sw_timeout_after: state=%0d memwrite=%b mem_timeout=%b expected 0 0 0", bus.state, bus.memwrite, bus.mem_timeout);
        end
    endtask

    task automatic test_bad_funct();
        build(32'h0022183F, 0, 0);
        drive(32'h0022183F);
        foreach (exp_q[i]) begin
            tests++;
            if ({obs_st[i], obs_cw[i]} !== {exp_q[i].st, exp_q[i].cw}) begin
                fails++;
                $display("FAIL bad_funct step %0d: state=%0d ctl=%05h expected state=%0d ctl=%05h", i, obs_st[i], obs_cw[i], exp_q[i].st, exp_q[i].cw);
            end
        end
    endtask

    task automatic test_branch();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] ins = (k == 0) ? 32'h10220004 : 32'h08000010;
            build(ins, 0, 0);
            drive(ins);
            foreach (exp_q[i]) begin
                tests++;
                if ({obs_st[i], obs_cw[i]} !== {exp_q[i].st, exp_q[i].cw}) begin
                    fails++;
                    $display("FAIL branch_jump %0d step %0d: state=%0d ctl=%05h expected state=%0d ctl=%05h", k, i, obs_st[i], obs_cw[i], exp_q[i].st, exp_q[i].cw);
                end
            end
        end
    endtask

    task automatic test_fetch_timeout();
        for (int k = 0; k < 2; k++) begin
            build(32'h00221820, (k == 0) ? -1 : TO, 0);
            drive(32'h00221820);
            foreach (exp_q[i]) begin
                tests++;
                if ({obs_st[i], obs_cw[i]} !== {exp_q[i].st, exp_q[i].cw}) begin
                    fails++;
                    $display("FAIL fetch_timeout %0d step %0d: state=%0d ctl=%05h expected state=%0d ctl=%05h", k, i, obs_st[i], obs_cw[i], exp_q[i].st, exp_q[i].cw);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            logic [31:0] ins = $urandom;
            int fw;
            int mw;
            int r = $urandom_range(0, 19);
            fw = (r == 0) ? -1 : ((r == 1) ? TO : int'($urandom_range(0, 3)));
            r = $urandom_range(0, 19);
            mw = (r < 3) ? -1 : ((r == 3) ? TO : ((r == 4) ? TO - 1 : int'($urandom_range(0, 3))));
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    ins[31:26] = 6'h00;
                    case ($urandom_range(0, 4))
                        0: ins[5:0] = 6'h20;
                        1: ins[5:0] = 6'h24;
                        2: ins[5:0] = 6'h25;
                        3: ins[5:0] = 6'h22;
                        default: ins[5:0] = 6'h2A;
                    endcase
                end
                3: ins[31:26] = 6'h00;
                4: ins[31:26] = 6'h08;
                5: ins[31:26] = 6'h23;
                6: ins[31:26] = 6'h2B;
                7: ins[31:26] = 6'h04;
                8: ins[31:26] = 6'h02;
                default: ;
            endcase
            build(ins, fw, mw);
            drive(ins);
            foreach (exp_q[i]) begin
                tests++;
                if ({obs_st[i], obs_cw[i]} !== {exp_q[i].st, exp_q[i].cw}) begin
                    fails++;
                    $display("FAIL random ins=%08h step %0d: state=%0d ctl=%05h expected state=%0d ctl=%05h", ins, i, obs_st[i], obs_cw[i], exp_q[i].st, exp_q[i].cw);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.instr = 32'hAC220004;
            bus.mem_ready = (i == 0) ? 1'b1 : ((i == 3) ? 1'b0 : rb());
        end
        #1;
        tests++;
        if ({bus.state, bus.memwrite, bus.mem_req} !== {4'd9, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL mid_write_setup: state=%0d memwrite=%b mem_req=%b expected 9 1 1", bus.state, bus.memwrite, bus.mem_req);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.state, bus.memwrite, bus.mem_req} !== {4'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_write_reset: state=%0d memwrite=%b mem_req=%b expected 0 0 0", bus.state, bus.memwrite, bus.mem_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.state !== 4'd0) begin
            fails++;
            $display("FAIL mid_write_release: state=%0d expected 0", bus.state);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_sw_timeout();
        test_bad_funct();
        test_branch();
        test_fetch_timeout();
        test_random();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle successor to the single-cycle decoder: an FSM sequences FETCH/DECODE/EXEC/MEM/WB over several clocks for add, and, or, sub, slt, addi, lw and sw.
- Adds a memory ready handshake with a timeout abort.
- Adds a parametrised ALU-op width.
- Adds optional beq/j support.
- Sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
- ALU_OP_W, 3: alu_op width. Must be ≥3; bits above [2:0] are driven 0.
- TIMEOUT, 15: maximum cycles spent waiting for mem_ready in any memory state. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction register contents
- mem_ready  in  1  memory completes the current access this cycle
- zero  in  1  ALU zero flag
- mem_req  out  1  memory access request
- iord  out  1  0 = address from PC, 1 = address from ALUOut
- memwrite  out  1  write strobe, qualifies mem_req
- irwrite  out  1  load IR
- pc_en  out  1  PC load enable
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- regwrite  out  1  register file write
- regdst  out  1  1 = rd, 0 = rt
- mem2reg  out  1  1 = MDR, 0 = ALUOut
- alusrc_a  out  1  0 = PC, 1 = rs
- alusrc_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  out  ALU_OP_W  000 add, 100 and, 010 or, 011 sub, 111 slt
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- mem_timeout  out  1  one-cycle pulse on a timeout abort
- state  out  4  current state, for debug

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset:
  - state resets to FETCH (0) and the wait counter to 0.
  - While rst_n=0, the strobes mem_req, memwrite, irwrite, pc_en, regwrite, illegal and mem_timeout are forced to 0.
  - Selects take their FETCH values: iord 0, alusrc_a 0, alusrc_b 01, alu_op 000, pcsrc 00.
- Output decode:
  - Outputs are decoded combinationally from state, plus mem_ready/zero/instr where noted.
  - Any signal not listed for a state is 0.
- States and transitions:
  - FETCH(0): mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, alu_op=add. irwrite and pc_en equal mem_ready. On mem_ready go to DECODE; otherwise hold.
  - DECODE(1): alusrc_a=0, alusrc_b=11, alu_op=add. Next state by instr[31:26]:
    - 000000 → EXEC
    - 001000 → ADDIEX
    - 100011 or 101011 → MEMADR
    - beq/j per the optional feature
    - anything else → illegal=1, go to FETCH
  - EXEC(2): alusrc_a=1, alusrc_b=00. alu_op from funct: 100000 add, 100100 and, 100101 or, 100010 sub, 101010 slt. A valid funct goes to ALUWB. An unknown funct gives illegal=1 and goes to FETCH with no register write.
  - ALUWB(3): regwrite=1, regdst=1, mem2reg=0; alu_op held from the funct decode. Go to FETCH.
  - ADDIEX(4): alusrc_a=1, alusrc_b=10, alu_op=add. Go to ADDIWB(5).
  - ADDIWB(5): regwrite=1, regdst=0. Go to FETCH.
  - MEMADR(6): alusrc_a=1, alusrc_b=10, alu_op=add. Go to MEMRD if opcode[3]=0, otherwise MEMWR.
  - MEMRD(7): mem_req=1, iord=1. On mem_ready go to MEMWB.
  - MEMWB(8): regwrite=1, regdst=0, mem2reg=1. Go to FETCH.
  - MEMWR(9): mem_req=1, memwrite=1, iord=1. On mem_ready go to FETCH.
- Timeout:
  - The wait counter clears on entry to FETCH, MEMRD and MEMWR, and increments on each cycle in those states with mem_ready=0.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready=0: pulse mem_timeout, go to FETCH, and do not assert irwrite, pc_en or regwrite for that access.
  - A FETCH timeout re-enters FETCH with the counter cleared.
  - If mem_ready and the timeout coincide, mem_ready wins.
- Counter width: $clog2(TIMEOUT+1), minimum 1.
- Reset mid-operation: the state returns to FETCH immediately, and a pending write strobe drops asynchronously.

Optional Feature:
- Macro: MC_CONTROLLER_BRANCH_EN.
- Defined:
  - DECODE routes 000100 to BRANCH(10) and 000010 to JUMP(11).
  - BRANCH: alusrc_a=1, alusrc_b=00, alu_op=sub, pcsrc=01, pc_en=zero. Go to FETCH.
  - JUMP: pcsrc=10, pc_en=1. Go to FETCH.
- Undefined: 000100 and 000010 are illegal opcodes (illegal pulse, go to FETCH), and states 10/11 are unreachable.

Test Plan:
1. add $3,$1,$2 (0x00221820) with mem_ready=1 in FETCH → states 0→1→2→3→0; ALUWB shows regwrite=1, regdst=1, alu_op=000; 4 cycles total.
2. lw (0x8C220004) with mem_ready held low 3 cycles in MEMRD → MEMRD holds 4 cycles, then MEMWB has regwrite=1, mem2reg=1; 8 cycles total.
3. sw (0xAC220004) with TIMEOUT=15 and mem_ready never asserted in MEMWR → mem_timeout pulses once after 15 wait cycles; state returns to 0; memwrite drops.
4. R-type with funct 0x3F → illegal pulses in EXEC; no regwrite; next state 0.
5. With MC_CONTROLLER_BRANCH_EN: beq with zero=1 → pc_en=1, pcsrc=01 in state 10. Without the macro: same instruction gives illegal=1 in DECODE.
6. Assert rst_n=0 mid-MEMWR → memwrite and mem_req are 0 immediately; state=0 after release.
